// File: rtl/io_ring_pwr_seq_pkg.sv
// rtl/io_ring_pwr_seq_pkg.sv - state encoding and parameter defaults for the IO ring power sequencer
package io_ring_pwr_seq_pkg;

  localparam int NGRP_DEFAULT    = 4;
  localparam int SETTLE_DEFAULT  = 16;
  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int STATE_W         = 3;

  // The enum values are exactly what appears on state_o.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_PG  = 3'd1,
    ST_RAMP     = 3'd2,
    ST_READY    = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } pwr_state_e;

endpackage

// File: rtl/io_ring_sync2.sv
// rtl/io_ring_sync2.sv - two-flop synchronizer for the asynchronous VDDIO power-good level
module io_ring_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_ring_pwr_seq.sv
// rtl/io_ring_pwr_seq.sv - IO ring power sequencer: waits for stable VDDIO, ramps pad groups, releases hold
// Counting the first edge that samples req=1 as edge 1 (pg already stable), ready is high after edge 2+SETTLE+NGRP*SETTLE; a WAIT_PG stay of TIMEOUT cycles ends in FAULT.
module io_ring_pwr_seq
  import io_ring_pwr_seq_pkg::*;
#(
  parameter int NGRP    = NGRP_DEFAULT,
  parameter int SETTLE  = SETTLE_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vddio_ok_a,
  input  logic               req,
  output logic [NGRP-1:0]    grp_en,
  output logic               pad_hold,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic            pg;
  pwr_state_e      state_q, state_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [SW-1:0]   step_q, step_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [NGRP-1:0] grp_en_d;
  logic            pad_hold_d, ready_d, fault_d;
  logic            enter_fault;

  io_ring_sync2 u_pg_sync (
    .clk (clk),
    .rst (rst),
    .d   (vddio_ok_a),
    .q   (pg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      stable_q <= '0;
      step_q   <= '0;
      tmo_q    <= '0;
      grp_en   <= '0;
      pad_hold <= 1'b1;
      ready    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
      grp_en   <= grp_en_d;
      pad_hold <= pad_hold_d;
      ready    <= ready_d;
      fault    <= fault_d;
    end
  end

  assign state_o = state_q;

  // Outputs are computed for the next state, so they land on the same edge as the transition.
  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    step_d      = step_q;
    tmo_d       = tmo_q;
    grp_en_d    = grp_en;
    pad_hold_d  = pad_hold;
    ready_d     = ready;
    fault_d     = fault;
    enter_fault = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d  = ST_WAIT_PG;
          stable_d = '0;
          tmo_d    = '0;
        end
      end

      ST_WAIT_PG: begin
        if (!req) begin
          state_d = ST_OFF;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          enter_fault = 1'b1;
        end else if (pg && stable_q == SW'(SETTLE)) begin
          state_d  = ST_RAMP;
          step_d   = '0;
          grp_en_d = {{(NGRP-1){1'b0}}, 1'b1};
        end else begin
          tmo_d    = tmo_q + TW'(1);
          stable_d = pg ? stable_q + SW'(1) : '0;
        end
      end

      ST_RAMP: begin
        if (!pg) begin
          enter_fault = 1'b1;
        end else if (!req) begin
          state_d = ST_SHUTDOWN;
          step_d  = '0;
        end else if (step_q == SW'(SETTLE - 1)) begin
          step_d = '0;
          if (grp_en[NGRP-1]) begin
            state_d    = ST_READY;
            pad_hold_d = 1'b0;
            ready_d    = 1'b1;
          end else begin
            grp_en_d = {grp_en[NGRP-2:0], 1'b1};
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end

      ST_READY: begin
        if (!pg) begin
          enter_fault = 1'b1;
        end else if (!req) begin
          state_d    = ST_SHUTDOWN;
          step_d     = '0;
          pad_hold_d = 1'b1;
          ready_d    = 1'b0;
        end
      end

      // The thermometer shifts down one group per settle period; one extra period after the last group.
      ST_SHUTDOWN: begin
        if (!pg) begin
          enter_fault = 1'b1;
        end else if (step_q == SW'(SETTLE - 1)) begin
          step_d = '0;
          if (grp_en == '0) begin
            state_d = ST_OFF;
          end else begin
            grp_en_d = grp_en >> 1;
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end

      ST_FAULT: begin
        if (!req) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    if (enter_fault) begin
      state_d    = ST_FAULT;
      grp_en_d   = '0;
      pad_hold_d = 1'b1;
      ready_d    = 1'b0;
      fault_d    = 1'b1;
    end
  end

endmodule

// File: doc/io_ring_pwr_seq.md
IO_RING_PWR_SEQ -- requirements
Module: io_ring_pwr_seq

Interface
REQ-001 SHALL have parameter NGRP, default 4, number of pad groups sequenced (2..8).
REQ-002 SHALL have parameter SETTLE, default 16, settle cycles per step (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles waiting for VDDIO good (SETTLE < TIMEOUT <= 65535).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port vddio_ok_a  in  1  VDDIO power-good from level detector; asynchronous to clk.
REQ-007 SHALL have port req  in  1  level; 1 = ring requested on, 0 = requested off.
REQ-008 SHALL have port grp_en  out  NGRP  per-group pad driver enable.
REQ-009 SHALL have port pad_hold  out  1  pad retention/hold; 1 = pad states frozen.
REQ-010 SHALL have port ready  out  1  ring fully up, hold released.
REQ-011 SHALL have port fault  out  1  sticky: power-good lost or timeout.
REQ-012 SHALL have port state_o  out  3  current FSM state encoding, for debug.

Function
REQ-013 SHALL synchronize vddio_ok_a through two flops; "pg" below denotes the synchronized value.
REQ-014 SHALL register all outputs; outputs change one cycle after the state transition causing them.
REQ-015 SHALL implement states OFF, WAIT_PG, RAMP, READY, SHUTDOWN, FAULT.
REQ-016 In OFF: grp_en=0, pad_hold=1, ready=0. On req=1, go to WAIT_PG with stable and timeout counters cleared.
REQ-017 In WAIT_PG: count consecutive cycles with pg=1; pg=0 resets the count. At count = SETTLE, go to RAMP with idx=0.
REQ-018 In WAIT_PG: a separate timeout counter increments every cycle; at TIMEOUT, go to FAULT.
REQ-019 In WAIT_PG: req=0 goes to OFF.
REQ-020 In RAMP: set grp_en[idx]=1 and wait SETTLE cycles. Then idx++. After group NGRP-1 settles, go to READY.
REQ-021 Enabled groups SHALL stay enabled during RAMP, so grp_en grows as a thermometer code from bit 0.
REQ-022 In READY: pad_hold=0, ready=1, grp_en all ones.
REQ-023 In READY, req=0 SHALL go to SHUTDOWN: pad_hold=1 and ready=0 on the next cycle. Groups then disable in reverse order (NGRP-1 down to 0), one every SETTLE cycles. After bit 0 clears and SETTLE elapses, go to OFF.
REQ-024 req=1 during RAMP SHALL be ignored until READY. req=0 during RAMP SHALL go to SHUTDOWN, starting from the highest enabled group.
REQ-025 req=1 during SHUTDOWN SHALL be ignored; the sequence completes to OFF, then restarts normally.
REQ-026 pg=0 in RAMP, READY or SHUTDOWN SHALL go to FAULT immediately. Next cycle: grp_en=0, pad_hold=1, ready=0, fault=1.
REQ-027 When pg drop and a req change occur in the same cycle, the pg drop SHALL take priority.
REQ-028 In FAULT: fault=1 and outputs stay as in REQ-026. Exit to OFF only when req=0; fault clears with that transition.
REQ-029 Counters SHALL be sized by $clog2 of their parameter; no wrap-around is reachable.
REQ-030 From req rise with pg already stable, ready SHALL assert after 2 + SETTLE + NGRP*SETTLE + 1 cycles (±1, fixed per implementation, documented in the header).

Reset
REQ-031 On rst=1: state=OFF, grp_en=0, pad_hold=1, ready=0, fault=0, state_o=OFF, all counters and sync flops = 0.
REQ-032 rst asserted mid-RAMP or in READY SHALL drop grp_en to 0 on the next edge; there is no graceful shutdown.

Structure
REQ-033 Package io_ring_pwr_seq_pkg SHALL hold the state enum (3-bit, OFF=0), the state_o encoding and the parameter defaults.
REQ-034 The 2-flop synchronizer SHALL be sub-module io_ring_sync2 (reset value 0). Everything else stays in one module.

Verification (NGRP=4, SETTLE=4, TIMEOUT=64)
REQ-035 Power-up: pg=1 held, req 0->1 -> grp_en goes 0001, 0011, 0111, 1111 at 4-cycle spacing; ready=1 and pad_hold=0 at the REQ-030 cycle count.
REQ-036 Power-down: from READY, req=0 -> pad_hold=1 next cycle, grp_en 0111, 0011, 0001, 0000 at 4-cycle spacing, then state OFF.
REQ-037 Glitchy PG: pg toggles every 3 cycles for 40 cycles, then stays high -> no RAMP until 4 stable cycles; with pg never high, fault=1 at 64 cycles.
REQ-038 PG loss: in READY, drop pg -> grp_en=0, fault=1 within 3 cycles of vddio_ok_a fall. req=0 -> OFF, fault=0. req=1 with pg=1 -> full ramp again.
REQ-039 Abort: req=0 when grp_en=0011 -> shutdown 0001, 0000, then OFF. Same-cycle pg drop plus req=0 in READY -> FAULT, not SHUTDOWN.
REQ-040 Reset in READY: rst=1 for 1 cycle -> all outputs at reset values next edge, state_o=0.
